// File: rtl/inflation_pkg.sv
// Shared definitions for the map-inflation datapath: scheduler state encoding,
// pad value, kernel half-height and the element packing order used by the unpacker.
package inflation_pkg;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 3'd0;
  localparam sched_state_t ST_FETCH = 3'd1;
  localparam sched_state_t ST_WAIT  = 3'd2;
  localparam sched_state_t ST_SEND  = 3'd3;
  localparam sched_state_t ST_DONE  = 3'd4;

  localparam int PAD_VALUE = 0;

  function automatic int half_of(input int kernel_size);
    return kernel_size / 2;
  endfunction

  // Element i of a packed word sits at bits [(i+1)*dw-1 -: dw].
  function automatic int slot_lsb(input int i, input int dw);
    return i * dw;
  endfunction

endpackage

// File: rtl/inflation_scan_scheduler_coord.sv
// Raster-order row/column counter for the scan scheduler: one step advances the
// column, wrapping into the next row; flags mark the last column and last cell.
module scan_coord_counter
  import inflation_pkg::*;
#(
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   step,
  input  logic [COORD_WIDTH-1:0] width,
  input  logic [COORD_WIDTH-1:0] height,
  output logic [COORD_WIDTH-1:0] row,
  output logic [COORD_WIDTH-1:0] col,
  output logic                   last_col,
  output logic                   last_cell
);

  assign last_col  = (col == width - COORD_WIDTH'(1));
  assign last_cell = last_col && (row == height - COORD_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (last_col) begin
        col <= '0;
        row <= row + COORD_WIDTH'(1);
      end else begin
        col <= col + COORD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/inflation_scan_scheduler.sv
// Scans the occupancy map in raster order and packs each cell's vertical kernel
// column into one AXI-Stream word. Optional stall counter: SCHED_PERF_CNT_EN.
module inflation_scan_scheduler
  import inflation_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int COORD_WIDTH = 10,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [COORD_WIDTH-1:0]            cfg_width,
  input  logic [COORD_WIDTH-1:0]            cfg_height,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_rd_en,
  output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]             mem_rd_data,
  output logic                              m_axis_tvalid,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [2:0]                        dbg_state
`ifdef SCHED_PERF_CNT_EN
  ,output logic [31:0]                      perf_stall_cycles
`endif
);

  // m_axis handshake: a word transfers in any cycle with tvalid && tready; once
  // tvalid is up, tdata/tlast stay frozen and tvalid holds until that transfer.
  localparam int HALF = half_of(KERNEL_SIZE);
  localparam int IW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int KW   = COORD_WIDTH + 1;
  localparam int WW   = KERNEL_SIZE * DATA_WIDTH;
  localparam logic [KW-1:0]         HALF_K = KW'(HALF);
  localparam logic [ADDR_WIDTH-1:0] HALF_A = ADDR_WIDTH'(HALF);
  localparam logic [IW-1:0]         IDX_LAST = IW'(KERNEL_SIZE - 1);

  sched_state_t            state_q;
  logic [IW-1:0]           idx;
  logic [COORD_WIDTH-1:0]  w_q, h_q;
  logic [ADDR_WIDTH-1:0]   row0_base, elem_base, start_base, w_step;
  logic                    rd_pend;
  logic [IW-1:0]           rd_slot;
  logic [WW-1:0]           slots;

  logic [COORD_WIDTH-1:0]  row, col;
  logic                    last_col, last_cell;
  logic                    start_ok, zero_dim, hs, fetch_rd, in_range;
  logic signed [KW-1:0]    row_k;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign zero_dim = (cfg_width == '0) || (cfg_height == '0);
  assign hs       = (state_q == ST_SEND) && m_axis_tready;
  assign w_step   = ADDR_WIDTH'(w_q);
  // Base of the topmost kernel row for row 0 sits HALF rows above the map.
  assign start_base = '0 - HALF_A * ADDR_WIDTH'(cfg_width);

  // Signed row index of the element being fetched; negative means above the map.
  assign row_k    = $signed({1'b0, row} - HALF_K + KW'(idx));
  assign in_range = !row_k[KW-1] && (row_k < $signed({1'b0, h_q}));
  assign fetch_rd = (state_q == ST_FETCH) && in_range;

  scan_coord_counter #(
    .COORD_WIDTH(COORD_WIDTH)
  ) u_coord (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .step     (hs && !last_cell),
    .width    (w_q),
    .height   (h_q),
    .row      (row),
    .col      (col),
    .last_col (last_col),
    .last_cell(last_cell)
  );

  assign mem_rd_en     = fetch_rd;
  assign mem_rd_addr   = fetch_rd ? (elem_base + ADDR_WIDTH'(col)) : '0;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tlast  = m_axis_tvalid && last_cell;
  assign m_axis_tdata  = slots;
  assign dbg_state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      row0_base <= '0;
      elem_base <= '0;
      rd_pend   <= 1'b0;
      rd_slot   <= '0;
      slots     <= '0;
    end else begin
      rd_pend <= fetch_rd;
      rd_slot <= idx;
      if (rd_pend) begin
        slots[slot_lsb(int'(rd_slot), DATA_WIDTH) +: DATA_WIDTH] <= mem_rd_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            w_q       <= cfg_width;
            h_q       <= cfg_height;
            idx       <= '0;
            row0_base <= start_base;
            elem_base <= start_base;
            state_q   <= zero_dim ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          elem_base <= elem_base + w_step;
          if (!in_range) begin
            slots[slot_lsb(int'(idx), DATA_WIDTH) +: DATA_WIDTH] <= DATA_WIDTH'(PAD_VALUE);
          end
          if (idx == IDX_LAST) begin
            idx     <= '0;
            state_q <= ST_WAIT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_WAIT: state_q <= ST_SEND;
        ST_SEND: begin
          if (m_axis_tready) begin
            if (last_cell) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_FETCH;
              if (last_col) begin
                row0_base <= row0_base + w_step;
                elem_base <= row0_base + w_step;
              end else begin
                elem_base <= row0_base;
              end
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_stall_cycles <= '0;
    end else if ((state_q == ST_SEND) && !m_axis_tready && (perf_stall_cycles != '1)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
